// File: rtl/op_sequencer_pkg.sv
// op_seq_pkg: shared FSM state type and instruction-word field layout for op_sequencer.
package op_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RR, F, WB} state_e;
  localparam int RA_LSB  = 0;
  localparam int RB_LSB  = 5;
  localparam int WA_LSB  = 10;
  localparam int OP_LSB  = 15;
  localparam int RW_BIT  = 19;
  localparam int INSTR_W = 20;
endpackage

// File: rtl/op_sequencer_if.sv
// op_sequencer_if: producer handshake plus datapath control outputs of op_sequencer.
interface op_sequencer_if;
  logic                           in_valid;
  logic                           in_ready;
  logic [op_seq_pkg::INSTR_W-1:0] in_instr;
  logic [4:0]                     R_Addr_A;
  logic [4:0]                     R_Addr_B;
  logic [4:0]                     W_Addr;
  logic [3:0]                     ALU_OP;
  logic                           Reg_Write;
  logic                           en_RR;
  logic                           en_F;
  logic                           en_WB;
  logic                           busy;
  logic                           done;
  logic [7:0]                     issued_cnt;
  modport master (
    output in_valid, in_instr,
    input  in_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
    input  en_RR, en_F, en_WB, busy, done, issued_cnt
  );
  modport slave (
    input  in_valid, in_instr,
    output in_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
    output en_RR, en_F, en_WB, busy, done, issued_cnt
  );
endinterface

// File: rtl/op_sequencer_instr_fifo.sv
// instr_fifo: synchronous FIFO, no fall-through; full/empty split by an extra pointer bit.
module instr_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: buffers operation words and issues each as LOAD/RR/F/WB with registered strobes.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  op_sequencer_if.slave bus
);
  state_e               state_q, state_d;
  logic                 empty, full, pop;
  logic [INSTR_W-1:0]   head, fields_q;
  logic                 en_rr_q, en_f_q, en_wb_q, done_q, busy_q;
  logic                 en_rr_d, en_f_d, en_wb_d, done_d, busy_d;
  logic [7:0]           cnt_q, cnt_d;
  assign pop = (state_q == IDLE) && !empty;
  instr_fifo #(.W(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid && !full),
    .pop_i   (pop),
    .data_i  (bus.in_instr),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb
    state_d = state_q == IDLE ? (empty ? IDLE : LOAD) :
              state_q == LOAD ? RR :
              state_q == RR   ? F  :
              state_q == F    ? WB : IDLE;
  // Strobes are registered from the current state, so each lags its phase by one cycle.
  always_comb begin
    en_rr_d = state_q == RR;
    en_f_d  = state_q == F;
    en_wb_d = (state_q == WB) && fields_q[RW_BIT];
    done_d  = state_q == WB;
    busy_d  = state_q != IDLE;
    cnt_d   = cnt_q + 8'(state_q == WB);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fields_q <= '0;
      en_rr_q  <= 1'b0;
      en_f_q   <= 1'b0;
      en_wb_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (pop) fields_q <= head;
      en_rr_q <= en_rr_d;
      en_f_q  <= en_f_d;
      en_wb_q <= en_wb_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.in_ready   = !full;
  assign bus.R_Addr_A   = fields_q[RA_LSB +: 5];
  assign bus.R_Addr_B   = fields_q[RB_LSB +: 5];
  assign bus.W_Addr     = fields_q[WA_LSB +: 5];
  assign bus.ALU_OP     = fields_q[OP_LSB +: 4];
  assign bus.Reg_Write  = fields_q[RW_BIT];
  assign bus.en_RR      = en_rr_q;
  assign bus.en_F       = en_f_q;
  assign bus.en_WB      = en_wb_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.issued_cnt = cnt_q;
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed-vector bench with immediate assertions for op_sequencer.
module tb_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  op_sequencer_if bus ();
  op_sequencer #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] strobes();
    return {bus.en_RR, bus.en_F, bus.en_WB, bus.done};
  endfunction
  function automatic logic [19:0] fields();
    return {bus.Reg_Write, bus.ALU_OP, bus.W_Addr, bus.R_Addr_B, bus.R_Addr_A};
  endfunction
  initial begin
    logic        any, v, r, wb_seen;
    logic [3:0]  s [1:6];
    logic [19:0] w4 [6];
    logic        rh [40];
    int          pi, di, last, np, nd;
    logic [7:0]  cnt255;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    for (int i = 0; i < 6; i++) w4[i] = {1'b1, 4'(i), 5'(i), 5'(i + 8), 5'(i + 16)};
    // reset and idle
    step(2);
    chk("rst_fields", fields(), 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.issued_cnt, 0);
    chk("rst_ready", bus.in_ready, 1);
    rst = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      any |= (strobes() != 0) || bus.busy;
    end
    chk("idle_quiet", any, 0);
    chk("idle_ready", bus.in_ready, 1);
    // single RW=1 operation: 88A41 -> RW=1 OP=1 WA=2 RB=18 RA=1
    bus.in_instr = 20'h88A41;
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    step(1);
    chk("t2_fields", fields(), 20'h88A41);
    chk("t2_ra", bus.R_Addr_A, 1);
    chk("t2_rb", bus.R_Addr_B, 18);
    chk("t2_wa", bus.W_Addr, 2);
    chk("t2_op", bus.ALU_OP, 1);
    chk("t2_e1_strobes", strobes(), 0);
    step(1);
    chk("t2_e2_busy", bus.busy, 1);
    chk("t2_e2_strobes", strobes(), 0);
    step(1);
    chk("t2_e3_rr", strobes(), 4'b1000);
    step(1);
    chk("t2_e4_f", strobes(), 4'b0100);
    step(1);
    chk("t2_e5_wb", strobes(), 4'b0011);
    chk("t2_e5_cnt", bus.issued_cnt, 1);
    chk("t2_e5_fields", fields(), 20'h88A41);
    step(1);
    chk("t2_e6_strobes", strobes(), 0);
    chk("t2_e6_busy", bus.busy, 0);
    chk("t2_e6_hold", fields(), 20'h88A41);
    // RW=0 operation
    bus.in_instr = {1'b0, 4'hA, 5'd3, 5'd4, 5'd5};
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    wb_seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      s[i] = strobes();
      wb_seen |= bus.en_WB;
    end
    chk("t3_rr", s[3], 4'b1000);
    chk("t3_f", s[4], 4'b0100);
    chk("t3_done", s[5], 4'b0001);
    chk("t3_no_wb", wb_seen, 0);
    chk("t3_cnt", bus.issued_cnt, 2);
    chk("t3_op", bus.ALU_OP, 4'hA);
    // six back-to-back words into a depth-4 FIFO
    pi = 0;
    di = 0;
    last = 0;
    for (int c = 0; c < 40; c++) begin
      v = pi < 6;
      bus.in_valid = v;
      bus.in_instr = w4[pi < 6 ? pi : 5];
      r = bus.in_ready;
      step(1);
      if (v && r) pi++;
      rh[c] = bus.in_ready;
      if (bus.done && di < 6) begin
        chk($sformatf("t4_word%0d", di), fields(), w4[di]);
        chk($sformatf("t4_gap%0d", di), c - last, 5);
        last = c;
        di++;
      end
    end
    bus.in_valid = 1'b0;
    chk("t4_pushed", pi, 6);
    chk("t4_completed", di, 6);
    chk("t4_ready_e3", rh[3], 1);
    chk("t4_ready_e4", rh[4], 0);
    chk("t4_ready_e5", rh[5], 0);
    chk("t4_ready_e6", rh[6], 1);
    chk("t4_ready_e7", rh[7], 0);
    chk("t4_ready_e11", rh[11], 1);
    chk("t4_cnt", bus.issued_cnt, 8);
    // reset during F phase with two words still queued
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = w4[i];
      bus.in_valid = 1'b1;
      step(1);
    end
    bus.in_valid = 1'b0;
    step(1);
    chk("t5_pre_rr", strobes(), 4'b1000);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_strobes", strobes(), 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_cnt", bus.issued_cnt, 0);
    chk("t5_fields", fields(), 0);
    chk("t5_ready", bus.in_ready, 1);
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      any |= (strobes() != 0) || bus.busy || (fields() != 0);
    end
    chk("t5_discarded", any, 0);
    // 256 operations wrap issued_cnt
    np = 0;
    nd = 0;
    cnt255 = '0;
    for (int c = 0; c < 2000 && nd < 256; c++) begin
      v = np < 256;
      bus.in_valid = v;
      bus.in_instr = {1'b0, 4'(c), 15'd0};
      r = bus.in_ready;
      step(1);
      if (v && r) np++;
      if (bus.done) begin
        nd++;
        if (nd == 255) cnt255 = bus.issued_cnt;
      end
    end
    bus.in_valid = 1'b0;
    chk("t6_completed", nd, 256);
    chk("t6_cnt255", cnt255, 255);
    chk("t6_wrap", bus.issued_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
